cascade_delay_sched: RTL and testbench
======================================

// Module: cascade_delay_sched
// PURPOSE
//  Address/enable sequencer for one dual-port LakeTop-style SRAM stage used as a
//  fixed-length delay line (line buffer) in a cascade. It converts a valid-qualified
//  input stream into waddr/wen/raddr/ren so that each output word equals the input
//  word DEPTH accepted samples earlier. A drain mode flushes the residue at end of frame.
//  Sits between the stream producer and the inner SRAM wrapper; stages may be chained.
// PARAMETERS
//  DW      16  data width
//  AW      16  SRAM address width; requires DEPTH <= 2**AW-1
//  DEPTH   64  delay in accepted samples; footprint is DEPTH+1 words at addresses 0..DEPTH
//  RD_LAT  1   SRAM read latency in cycles (ren to rdata valid), >= 1
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset, asynchronous assert, active-low
//  flush      in   1   synchronous clear to IDLE; also forwarded to the SRAM by the parent
//  in_valid   in   1   input word valid
//  in_data    in   DW  input word
//  in_ready   out  1   1 in IDLE/FILL/STEADY, 0 in DRAIN
//  drain_req  in   1   single-cycle pulse: emit all buffered words, then return to IDLE
//  wdata      out  DW  SRAM write data (= in_data)
//  waddr      out  AW  SRAM write address (= wptr)
//  wen        out  1   SRAM write enable
//  raddr      out  AW  SRAM read address (= rptr)
//  ren        out  1   SRAM read enable
//  rdata      in   DW  SRAM read data
//  out_valid  out  1   output word valid
//  out_data   out  DW  output word (= rdata, passed through)
//  busy       out  1   state != IDLE, or read pipe non-empty
// BEHAVIOUR
//  State: wptr, rptr in 0..DEPTH (wrap DEPTH->0); count in 0..DEPTH;
//   vpipe[RD_LAT] valid shift register; FSM IDLE/FILL/STEADY/DRAIN.
//  Reset (rst_n=0): all of the above cleared, FSM=IDLE. wen=ren=out_valid=busy=0,
//   waddr=raddr=0, in_ready=1.
//  Accept = in_valid & in_ready. wen, waddr, wdata are combinational from accept, wptr, in_data.
//  IDLE/FILL: accept -> wen=1 @wptr; wptr++, count++; ren=0. Leave IDLE on first accept.
//   FILL -> STEADY on the edge where count reaches DEPTH.
//  STEADY (count==DEPTH): accept -> wen=1 @wptr AND ren=1 @rptr the same cycle;
//   wptr++, rptr++; count unchanged. The addresses never collide (wptr == rptr+DEPTH mod DEPTH+1).
//  ren pushes 1 into vpipe; out_valid = vpipe[RD_LAT-1]; out_data = rdata.
//   Output appears exactly RD_LAT cycles after the read is issued.
//  drain_req sampled in IDLE: ignored. In FILL/STEADY: -> DRAIN next cycle.
//   A same-cycle accept is still written and counted.
//  DRAIN: in_ready=0, wen=0. Each cycle with count>0: ren=1 @rptr, rptr++, count--.
//   When count==0 and vpipe all zero: -> IDLE, wptr=rptr=0.
//  flush=1: next edge forces IDLE and clears pointers, count and vpipe; no wen/ren is
//   issued that cycle. flush has priority over accept and drain_req.
//  DEPTH=1 is legal: STEADY is entered after one word, with a delay of one sample.
//  in_valid gaps in STEADY stall both pointers; no reads are issued while idle.
// TESTING
//  1 DEPTH=4,RD_LAT=1: accept 1..5 back-to-back -> on 5th: wen@4, ren@0;
//    next cycle out_valid=1, out_data=1.
//  2 Stream 1..20 with random in_valid gaps -> outputs exactly 1..16 in order, no
//    duplicates; waddr wraps 4->0 on the 6th write.
//  3 Accept 1..6, then drain_req -> in_ready=0, ren@2,3,4,0 on consecutive cycles,
//    outputs 3,4,5,6, busy falls after last output, pointers=0.
//  4 drain_req in FILL after 2 words -> outputs 1,2; then IDLE; drain_req in IDLE -> no effect.
//  5 flush mid-STEADY, same cycle as in_valid -> no wen/ren that cycle, IDLE,
//    next accept written @0, out_valid stays 0 until 4 more words are accepted.
//  6 rst_n low mid-DRAIN, async -> all outputs 0 immediately, in_ready=1; RD_LAT=3 rerun of test 1
//    -> out_valid 3 cycles after ren.

Source files
------------

// File: rtl/cascade_delay_sched.sv
// Address/enable sequencer that turns one dual-port SRAM into a DEPTH-sample
// delay line. The footprint is DEPTH+1 words. A write and a read in the same
// cycle therefore never share an address. The drain mode flushes the residue
// out at end of frame.
module cascade_delay_sched #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          drain_req,
  output logic [DW-1:0] wdata,
  output logic [AW-1:0] waddr,
  output logic          wen,
  output logic [AW-1:0] raddr,
  output logic          ren,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FILL, STEADY, DRAIN} state_t;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW-1:0]     count_q, count_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic              accept;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == DEPTH_A) ? '0 : p + AW'(1);
  endfunction

  // State, pointers, occupancy and read-valid pipe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      vpipe_q <= vpipe_d;
    end
  end

  // SRAM strobes and stream handshake for the current cycle
  always_comb begin
    in_ready  = (state_q != DRAIN);
    accept    = in_valid & in_ready & ~flush;
    wen       = accept;
    wdata     = in_data;
    waddr     = wptr_q;
    raddr     = rptr_q;
    ren       = 1'b0;
    if (!flush) begin
      if (state_q == STEADY)     ren = accept;
      else if (state_q == DRAIN) ren = (count_q != '0);
    end
    out_valid = vpipe_q[RD_LAT-1];
    out_data  = rdata;
    busy      = (state_q != IDLE) | (|vpipe_q);
  end

  // Next state, pointer advance and occupancy bookkeeping
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Shift in the read strobe; the truncating cast keeps this valid for RD_LAT==1
    vpipe_d = RD_LAT'({vpipe_q, ren});
    if (wen) wptr_d = ptr_inc(wptr_q);
    if (ren) rptr_d = ptr_inc(rptr_q);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          count_d = count_q + AW'(1);
          state_d = (count_q + AW'(1) == DEPTH_A) ? STEADY : FILL;
        end
      end
      FILL: begin
        if (accept) count_d = count_q + AW'(1);
        if (drain_req)                                      state_d = DRAIN;
        else if (accept && (count_q + AW'(1) == DEPTH_A)) state_d = STEADY;
      end
      STEADY: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (ren) count_d = count_q - AW'(1);
        if ((count_q == '0) && (vpipe_q == '0)) begin
          state_d = IDLE;
          wptr_d  = '0;
          rptr_d  = '0;
        end
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      vpipe_d = '0;
    end
  end

endmodule

// File: tb/tb_cascade_delay_sched.sv
// Bench for cascade_delay_sched: three instances share one random/directed
// input stream (DEPTH/RD_LAT = 4/1, 4/3, 1/2), each backed by a small SRAM
// model, and are checked every cycle against a sample-count reference model.
module tb_cascade_delay_sched;

  localparam int N = 3;
  localparam int DEP [N] = '{4, 4, 1};
  localparam int LAT [N] = '{1, 3, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        drain_req = 1'b0;
  logic [15:0] in_data = '0;

  logic        in_ready_w [N];
  logic        wen_w      [N];
  logic        ren_w      [N];
  logic        out_valid_w[N];
  logic        busy_w     [N];
  logic [15:0] wdata_w    [N];
  logic [15:0] waddr_w    [N];
  logic [15:0] raddr_w    [N];
  logic [15:0] rdata_w    [N];
  logic [15:0] out_data_w [N];

  always #5 clk = ~clk;

  cascade_delay_sched #(.DW(16), .AW(16), .DEPTH(4), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[0]), .drain_req(drain_req), .wdata(wdata_w[0]),
    .waddr(waddr_w[0]), .wen(wen_w[0]), .raddr(raddr_w[0]), .ren(ren_w[0]),
    .rdata(rdata_w[0]), .out_valid(out_valid_w[0]), .out_data(out_data_w[0]),
    .busy(busy_w[0]));

  cascade_delay_sched #(.DW(16), .AW(16), .DEPTH(4), .RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[1]), .drain_req(drain_req), .wdata(wdata_w[1]),
    .waddr(waddr_w[1]), .wen(wen_w[1]), .raddr(raddr_w[1]), .ren(ren_w[1]),
    .rdata(rdata_w[1]), .out_valid(out_valid_w[1]), .out_data(out_data_w[1]),
    .busy(busy_w[1]));

  cascade_delay_sched #(.DW(16), .AW(16), .DEPTH(1), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[2]), .drain_req(drain_req), .wdata(wdata_w[2]),
    .waddr(waddr_w[2]), .wen(wen_w[2]), .raddr(raddr_w[2]), .ren(ren_w[2]),
    .rdata(rdata_w[2]), .out_valid(out_valid_w[2]), .out_data(out_data_w[2]),
    .busy(busy_w[2]));

  // SRAM models: write on wen, read data emerges LAT cycles after the address
  logic [15:0] mem [N][0:15];
  logic [15:0] rp  [N][0:3];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (wen_w[k]) mem[k][waddr_w[k][3:0]] <= wdata_w[k];
      rp[k][0] <= mem[k][raddr_w[k][3:0]];
      for (int i = 1; i < 4; i++) rp[k][i] <= rp[k][i-1];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) rdata_w[k] = rp[k][LAT[k]-1];
  end

  // Reference model: words written/read in the current frame, drain flag,
  // and a schedule of expected outputs indexed by cycle number modulo 8.
  int unsigned nw  [N];
  int unsigned nr  [N];
  bit          drn [N];
  logic [15:0] hist[N][0:255];
  bit          sv  [N][0:7];
  logic [15:0] sd  [N][0:7];
  int unsigned cyc = 0;

  int checks = 0;
  int fails  = 0;
  bit logging = 1'b0;
  logic [15:0] olog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      nw[k] = 0; nr[k] = 0; drn[k] = 1'b0;
      for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, check every instance, advance the model
  task automatic step(input logic v, input logic [15:0] d, input logic dr, input logic fl);
    in_valid = v; in_data = d; drain_req = dr; flush = fl;
    #2;
    for (int k = 0; k < N; k++) begin
      bit acc, stdy, rexp, pend, sdrain, stop;
      int unsigned slot;
      slot = cyc % 8;
      pend = 1'b0;
      for (int s = 0; s < 8; s++) pend |= sv[k][s];
      acc  = v && !drn[k] && !fl;
      stdy = !drn[k] && (nw[k] - nr[k] == DEP[k]);
      rexp = !fl && ((stdy && acc) || (drn[k] && nw[k] > nr[k]));
      chk($sformatf("u%0d.in_ready", k), in_ready_w[k], !drn[k]);
      chk($sformatf("u%0d.wen", k), wen_w[k], acc);
      if (acc) chk($sformatf("u%0d.wdata", k), wdata_w[k], d);
      chk($sformatf("u%0d.waddr", k), waddr_w[k], nw[k] % (DEP[k] + 1));
      chk($sformatf("u%0d.ren", k), ren_w[k], rexp);
      chk($sformatf("u%0d.raddr", k), raddr_w[k], nr[k] % (DEP[k] + 1));
      chk($sformatf("u%0d.out_valid", k), out_valid_w[k], sv[k][slot]);
      if (sv[k][slot]) chk($sformatf("u%0d.out_data", k), out_data_w[k], sd[k][slot]);
      chk($sformatf("u%0d.busy", k), busy_w[k], drn[k] || nw[k] > 0 || pend);
      if (k == 0 && logging && out_valid_w[0]) olog.push_back(out_data_w[0]);
      if (fl) begin
        nw[k] = 0; nr[k] = 0; drn[k] = 1'b0;
        for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
      end else begin
        sdrain = dr && !drn[k] && nw[k] > 0;
        stop   = drn[k] && nw[k] == nr[k] && !pend;
        sv[k][slot] = 1'b0;
        if (acc) begin
          hist[k][nw[k] % 256] = d;
          nw[k]++;
        end
        if (rexp) begin
          sv[k][(cyc + LAT[k]) % 8] = 1'b1;
          sd[k][(cyc + LAT[k]) % 8] = hist[k][nr[k] % 256];
          nr[k]++;
        end
        if (sdrain) drn[k] = 1'b1;
        if (stop) begin
          drn[k] = 1'b0; nw[k] = 0; nr[k] = 0;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit any_active();
    bit a;
    a = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (drn[k] || nw[k] > 0) a = 1'b1;
      for (int s = 0; s < 8; s++) a |= sv[k][s];
    end
    return a;
  endfunction

  // Request a drain and idle until every model instance is back to IDLE
  task automatic drain_all(input int maxc);
    int n;
    step(1'b0, '0, 1'b1, 1'b0);
    n = 0;
    while (any_active() && n < maxc) begin
      step(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    chk("drain_timeout", {31'd0, any_active()}, 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s.u%0d.wen", tag, k), wen_w[k], 1'b0);
      chk($sformatf("%s.u%0d.ren", tag, k), ren_w[k], 1'b0);
      chk($sformatf("%s.u%0d.out_valid", tag, k), out_valid_w[k], 1'b0);
      chk($sformatf("%s.u%0d.busy", tag, k), busy_w[k], 1'b0);
      chk($sformatf("%s.u%0d.waddr", tag, k), waddr_w[k], 16'd0);
      chk($sformatf("%s.u%0d.raddr", tag, k), raddr_w[k], 16'd0);
      chk($sformatf("%s.u%0d.in_ready", tag, k), in_ready_w[k], 1'b1);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Five back-to-back words: first steady read on the fifth for DEPTH=4
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
    drain_all(60);

    // Stream 1..20 with random gaps
    begin
      int sent, n;
      sent = 1; n = 0;
      while (sent <= 20 && n < 200) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        step(v, 16'(sent), 1'b0, 1'b0);
        if (v) sent++;
        n++;
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
    drain_all(60);

    // Six words then drain: DEPTH=4 delay line must emit exactly 1..6
    olog.delete();
    logging = 1'b1;
    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    drain_all(60);
    logging = 1'b0;
    chk("t3.count", olog.size(), 32'd6);
    for (int i = 0; i < olog.size() && i < 6; i++)
      chk($sformatf("t3.word%0d", i), olog[i], 16'(i + 1));

    // Drain from FILL after two words, then drain_req while IDLE
    step(1'b1, 16'd1, 1'b0, 1'b0);
    step(1'b1, 16'd2, 1'b0, 1'b0);
    drain_all(60);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Flush in STEADY with a valid word present, then refill from address 0
    for (int i = 1; i <= 7; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'd99, 1'b0, 1'b1);
    for (int i = 10; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    drain_all(60);

    // Random soak with gaps, drains and flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 16'($urandom),
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end
    drain_all(60);

    // Asynchronous reset in the middle of a drain
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i + 100), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Rerun of the five-word case after reset, all latencies
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i + 200), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
    drain_all(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
